lzw_out_buffer: RTL and testbench
=================================

Name: lzw_out_buffer

Overview:
- Output-side stage downstream of the microcoded LZW controller: consumes the controller's RequestOutBuffer and CloseBuffer strobes and the code word currently held in the code/dictionary datapath.
- Packs variable-count CODE_WIDTH-bit codes MSB-first into OUT_WIDTH-bit bytes.
- Queues the bytes in a small FIFO and presents them to the file writer over a valid/ready handshake.
- Provides Busy back-pressure that the microprogram polls as a jump condition, and signals completion after the close flush.

Parameters:
- CODE_WIDTH, 9, width of one emitted code; legal range OUT_WIDTH+1 .. 2*OUT_WIDTH.
- OUT_WIDTH, 8, width of one output byte.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- RequestOutBuffer  in  1  one-cycle strobe: append Code to the bit stream.
- Code  in  CODE_WIDTH  code value, sampled on the cycle RequestOutBuffer=1.
- CloseBuffer  in  1  one-cycle strobe: flush the partial byte and finish.
- Busy  out  1  1 = controller must not strobe RequestOutBuffer or CloseBuffer.
- Done  out  1  1 = stream closed and every byte consumed.
- Overflow  out  1  sticky error: a strobe arrived while Busy=1.
- out_data  out  OUT_WIDTH  FIFO head byte.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (asynchronous) values:
  - state=ACTIVE; acc=0; count=0; FIFO emptied.
  - Busy=0, Done=0, Overflow=0, out_valid=0, out_data=0.
  - Reset mid-operation discards all pending bits and bytes; no partial byte is emitted.
- Accumulator:
  - acc is CODE_WIDTH+OUT_WIDTH-1 bits wide; count holds the number of valid bits, right-aligned in acc.
  - Accept, when RequestOutBuffer=1 and Busy=0: acc <= (acc<<CODE_WIDTH)|Code; count <= count+CODE_WIDTH.
- Extract:
  - Condition: count>=OUT_WIDTH and the FIFO is not full.
  - Push acc[count-1 -: OUT_WIDTH]; count <= count-OUT_WIDTH.
  - At most one extract per cycle.
  - Accept and extract never coincide, because Busy blocks accept.
- Busy is registered-state combinational: Busy = (count>=OUT_WIDTH) | fifo_full | (state!=ACTIVE).
- Latency:
  - Code accepted at edge N → first byte pushed at edge N+1 (if the FIFO has room) → out_valid=1 after edge N+1.
  - A second byte (when count reaches 2*OUT_WIDTH or more) is pushed at edge N+2.
- FIFO:
  - out_valid = !empty; out_data = head.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are allowed when not full.
  - When full, push waits for a pop on an earlier cycle; a simultaneous pop does not unblock the push.
- States:
  - ACTIVE:
    - CloseBuffer=1 & Busy=0 → FLUSH.
    - A strobe while Busy=1 is ignored and sets Overflow.
    - If both strobes arrive together while Busy=0: accept the code first, then go to FLUSH.
  - FLUSH:
    - Extract normally while count>=OUT_WIDTH.
    - Then, if 0<count<OUT_WIDTH and the FIFO is not full: push the remaining bits left-justified, zero-padded in the LSBs; count <= 0.
    - When count==0 and the FIFO is empty → CLOSED.
  - CLOSED:
    - Done=1, Busy=1.
    - Any strobe sets Overflow and is otherwise ignored.
    - Only reset leaves CLOSED.
- Overflow stays set until reset.
- CloseBuffer with count==0 emits no pad byte.

Decomposition:
- Shared package lzw_pkg holds:
  - the state encoding (ACTIVE, FLUSH, CLOSED);
  - CODE_WIDTH and OUT_WIDTH defaults;
  - the Busy jump-condition select code used by the controller microprogram.
- One natural sub-module: lzw_byte_fifo (synchronous FIFO, parameters OUT_WIDTH and FIFO_DEPTH, push/pop/full/empty, same clk and asynchronous active-high reset).

Test Plan:
1. Basic pack: out_ready=1; accept 0x155 then 0x0AA; pulse CloseBuffer → out_data sequence 0xAA, 0xAA, 0x80; Done=1 only after the last pop.
2. Latency: accept 0x1FF at edge N → Busy=1 and count=9 in cycle N; out_valid=1 after edge N+1 with out_data=0xFF.
3. Back-pressure: out_ready=0; accept codes until the FIFO holds 4 bytes → Busy stays 1; raising out_ready drains bytes in order, Busy drops, and no byte is lost or duplicated.
4. Overflow: pulse RequestOutBuffer while Busy=1 → code dropped, Overflow=1; the subsequent byte stream excludes the dropped code; Overflow holds until reset.
5. Empty close: CloseBuffer with count=0 and FIFO empty → CLOSED on the next edge; Done=1; no byte emitted; a later strobe sets Overflow.
6. Reset mid-flush: in FLUSH with 2 bytes queued, assert reset asynchronously → out_valid=0, Busy=0, Done=0 immediately; no pad byte after release.

Source files
------------

// File: rtl/lzw_pkg.sv
// Shared definitions for the LZW output stage: state encoding, default widths
// and the microprogram jump-condition code that selects the Busy flag.
package lzw_pkg;

    localparam int CODE_WIDTH_DEF = 9;
    localparam int OUT_WIDTH_DEF  = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_CLOSED = 2'd2;

    // Condition-select value the controller microcode uses to branch on Busy.
    localparam logic [3:0] JC_OUT_BUSY = 4'd6;

endpackage

// File: rtl/lzw_out_buffer_if.sv
// Byte stream handshake between the output buffer (master) and the file
// writer (slave).
interface lzw_out_buffer_if
    import lzw_pkg::*;
#(
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
);
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lzw_byte_fifo.sv
// Small synchronous FIFO for packed output bytes; head is presented
// combinationally and reads as zero while empty.
module lzw_byte_fifo
    import lzw_pkg::*;
#(
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic [OUT_WIDTH-1:0] din_i,
    input  logic                 pop_i,
    output logic [OUT_WIDTH-1:0] dout_o,
    output logic                 full_o,
    output logic                 empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]          wr_q, wr_d;
    logic [AW:0]          rd_q, rd_d;
    logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                 do_push;
    logic                 do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/lzw_out_buffer.sv
// Packs LZW codes MSB-first into bytes, queues them for the file writer and
// gives the microprogram Busy back-pressure plus close/flush completion.
module lzw_out_buffer
    import lzw_pkg::*;
#(
    parameter int CODE_WIDTH = CODE_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RequestOutBuffer,
    input  logic [CODE_WIDTH-1:0] Code,
    input  logic                  CloseBuffer,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Overflow,
    lzw_out_buffer_if.master      out_if
);
    localparam int ACC_W = CODE_WIDTH + OUT_WIDTH - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] OUT_W_C  = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0] CODE_W_C = CNT_W'(CODE_WIDTH);

    logic [1:0]           state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;

    logic                 have_byte;
    logic                 accept;
    logic                 close_ok;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [OUT_WIDTH-1:0] push_data;
    logic [OUT_WIDTH-1:0] extract_byte;
    logic [OUT_WIDTH-1:0] low_bits;
    logic [OUT_WIDTH-1:0] pad_byte;

    assign have_byte = (count_q >= OUT_W_C);
    assign Busy      = have_byte || fifo_full || (state_q != ST_ACTIVE);
    assign Done      = (state_q == ST_CLOSED);
    assign Overflow  = ovf_q;
    assign accept    = RequestOutBuffer && !Busy;
    assign close_ok  = CloseBuffer && !Busy;
    assign fifo_pop  = out_if.out_valid && out_if.out_ready;

    // Valid bits are right-aligned; anything above count_q is stale and is
    // discarded by the truncating casts/shifts below.
    assign extract_byte = OUT_WIDTH'(acc_q >> (count_q - OUT_W_C));
    assign low_bits     = acc_q[OUT_WIDTH-1:0];
    assign pad_byte     = low_bits << (OUT_W_C - count_q);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        ovf_d     = ovf_q || ((RequestOutBuffer || CloseBuffer) && Busy);
        fifo_push = 1'b0;
        push_data = extract_byte;

        if (have_byte && !fifo_full) begin
            fifo_push = 1'b1;
            count_d   = count_q - OUT_W_C;
        end else if ((state_q == ST_FLUSH) && (count_q != '0) && !fifo_full) begin
            fifo_push = 1'b1;
            push_data = pad_byte;
            count_d   = '0;
        end

        if (accept) begin
            acc_d   = (acc_q << CODE_WIDTH) | ACC_W'(Code);
            count_d = count_q + CODE_W_C;
        end

        case (state_q)
            ST_ACTIVE: begin
                // Nothing left to flush: skip straight to CLOSED.
                if (close_ok)
                    state_d = ((count_q == '0) && fifo_empty && !accept) ? ST_CLOSED : ST_FLUSH;
            end
            ST_FLUSH: begin
                if ((count_q == '0) && fifo_empty) state_d = ST_CLOSED;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACTIVE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    lzw_byte_fifo #(
        .OUT_WIDTH  (OUT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   (push_data),
        .pop_i   (fifo_pop),
        .dout_o  (out_if.out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_if.out_valid = !fifo_empty;

endmodule

// File: tb/tb_lzw_out_buffer.sv
// Directed and randomized bench for lzw_out_buffer; expected bytes come from a
// bit-queue model of the MSB-first packing rules.
module tb_lzw_out_buffer;
    localparam int CW = 9;
    localparam int OW = 8;

    logic          clk;
    logic          reset;
    logic          req;
    logic [CW-1:0] code;
    logic          close;
    logic          busy;
    logic          done;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    bit       bitq [$];
    logic [7:0] got [$];
    logic     ovf_m;

    lzw_out_buffer_if #(.OUT_WIDTH(OW)) ifc ();

    lzw_out_buffer #(
        .CODE_WIDTH (CW),
        .OUT_WIDTH  (OW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .RequestOutBuffer (req),
        .Code             (code),
        .CloseBuffer      (close),
        .Busy             (busy),
        .Done             (done),
        .Overflow         (ovf),
        .out_if           (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, called just after a falling edge: drive the strobes,
    // advance the model with what the next rising edge will see, then wait.
    task automatic step(input logic r, input logic [CW-1:0] c, input logic cl, input logic rdy);
        logic [7:0] e;
        req           = r;
        code          = c;
        close         = cl;
        ifc.out_ready = rdy;
        if ((r || cl) && busy) ovf_m = 1'b1;
        if (r && !busy)
            for (int i = CW - 1; i >= 0; i--) bitq.push_back(c[i]);
        if (cl && !busy)
            while ((bitq.size() % OW) != 0) bitq.push_back(1'b0);
        if (ifc.out_valid && rdy) begin
            got.push_back(ifc.out_data);
            if (bitq.size() >= OW) begin
                for (int i = OW - 1; i >= 0; i--) e[i] = bitq.pop_front();
                chk("byte", {24'd0, ifc.out_data}, {24'd0, e});
            end else begin
                chk("byte_extra", {31'd0, ifc.out_valid}, 32'd0);
            end
        end
        @(negedge clk);
        req   = 1'b0;
        close = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 1'b0;
        close = 1'b0;
        code  = '0;
        @(negedge clk);
        reset = 1'b0;
        bitq.delete();
        got.delete();
        ovf_m = 1'b0;
    endtask

    task automatic wait_idle(input logic rdy);
        int n = 0;
        while (busy && n < 60) begin
            step(1'b0, '0, 1'b0, rdy);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((ifc.out_valid || busy) && n < 100) begin
            step(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("drain_timeout", {31'd0, ifc.out_valid || busy}, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            if (ifc.out_valid) chk("done_early", {31'd0, done}, 32'd0);
            step(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [7:0] basic_exp [3];
        basic_exp[0] = 8'hAA;
        basic_exp[1] = 8'hAA;
        basic_exp[2] = 8'h80;
        ifc.out_ready = 1'b0;
        ovf_m = 1'b0;
        reset = 1'b1;
        req   = 1'b0;
        close = 1'b0;
        code  = '0;
        #1;
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf}, 32'd0);
        chk("rst_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_data",  {24'd0, ifc.out_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic pack: 0x155, 0x0AA, close -> AA AA 80.
        do_reset();
        step(1'b1, 9'h155, 1'b0, 1'b1);
        wait_idle(1'b1);
        step(1'b1, 9'h0AA, 1'b0, 1'b1);
        wait_idle(1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        wait_done();
        chk("basic_count", got.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < got.size()) chk("basic_seq", {24'd0, got[i]}, {24'd0, basic_exp[i]});
        chk("basic_valid", {31'd0, ifc.out_valid}, 32'd0);

        // Latency of the first byte.
        do_reset();
        step(1'b1, 9'h1FF, 1'b0, 1'b0);
        chk("lat_busy",   {31'd0, busy}, 32'd1);
        chk("lat_valid0", {31'd0, ifc.out_valid}, 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("lat_valid1", {31'd0, ifc.out_valid}, 32'd1);
        chk("lat_data",   {24'd0, ifc.out_data}, 32'hFF);
        drain();

        // Back-pressure: fill the FIFO, then drain in order.
        do_reset();
        for (int i = 0; i < 40; i++)
            step(!busy, CW'($urandom), 1'b0, 1'b0);
        chk("bp_busy",  {31'd0, busy}, 32'd1);
        chk("bp_valid", {31'd0, ifc.out_valid}, 32'd1);
        drain();
        chk("bp_left", {31'd0, bitq.size() < OW}, 32'd1);
        chk("bp_ovf",  {31'd0, ovf}, {31'd0, ovf_m});

        // Overflow: strobe while Busy drops the code and sets a sticky flag.
        do_reset();
        step(1'b1, 9'h0F0, 1'b0, 1'b1);
        step(1'b1, 9'h1C3, 1'b0, 1'b1);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        wait_idle(1'b1);
        step(1'b1, 9'h03C, 1'b0, 1'b1);
        wait_idle(1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        wait_done();
        chk("ovf_hold", {31'd0, ovf}, 32'd1);
        chk("ovf_bytes", got.size(), 32'd3);

        // Empty close.
        do_reset();
        step(1'b0, '0, 1'b1, 1'b1);
        chk("ec_done",  {31'd0, done}, 32'd1);
        chk("ec_busy",  {31'd0, busy}, 32'd1);
        chk("ec_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("ec_ovf0",  {31'd0, ovf}, 32'd0);
        step(1'b1, 9'h001, 1'b0, 1'b1);
        chk("ec_ovf1",  {31'd0, ovf}, 32'd1);
        chk("ec_none",  got.size(), 32'd0);

        // Reset mid-flush with two bytes queued.
        do_reset();
        step(1'b1, 9'h155, 1'b0, 1'b0);
        wait_idle(1'b0);
        step(1'b1, 9'h0AA, 1'b0, 1'b0);
        wait_idle(1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("mf_valid_pre", {31'd0, ifc.out_valid}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mf_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("mf_busy",  {31'd0, busy}, 32'd0);
        chk("mf_done",  {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bitq.delete();
        got.delete();
        ovf_m = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("mf_nopad", got.size(), 32'd0);
        chk("mf_busy2", {31'd0, busy}, 32'd0);

        // Randomized traffic against the bit-queue model.
        do_reset();
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 2) == 0, CW'($urandom), 1'b0, $urandom_range(0, 3) != 0);
        wait_idle(1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        wait_done();
        chk("rnd_left", bitq.size(), 32'd0);
        chk("rnd_ovf",  {31'd0, ovf}, {31'd0, ovf_m});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
